// File: rtl/sync_fifo_pkg.sv
// Shared types, defaults and sizing helpers for the parametrised single-clock FIFO.
package sync_fifo_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_DEPTH  = 16;

  typedef enum logic {
    MODE_STD,
    MODE_FWFT
  } fifo_mode_t;

  // Address width that stays at least one bit wide for degenerate depths.
  function automatic int unsigned addr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x DATA_W register array: one synchronous write port, one asynchronous read port.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned ADDR_W = addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with standard or first-word-fall-through read,
// almost-full/almost-empty thresholds, fill level and sticky error flags.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned DEPTH     = DEF_DEPTH,
  parameter int unsigned FWFT      = 0,
  parameter int unsigned AF_THRESH = DEPTH - 2,
  parameter int unsigned AE_THRESH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     valid,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     underflow,
  input  logic                     clear_err
);

  localparam int unsigned ADDR_W = addr_w(DEPTH);
  localparam int unsigned LW     = $clog2(DEPTH) + 1;
  localparam fifo_mode_t  MODE   = (FWFT != 0) ? MODE_FWFT : MODE_STD;

  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] AF_L    = LW'(AF_THRESH);
  localparam logic [LW-1:0] AE_L    = LW'(AE_THRESH);

  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]     level_q, level_d;
  logic              empty_q, full_q, afull_q, aempty_q;
  logic              overflow_q, underflow_q, overflow_d, underflow_d;
  logic              wr_acc, rd_acc;
  logic [DATA_W-1:0] mem_rdata;

  // Acceptance is judged on the flags registered before this edge.
  assign wr_acc = wr_en && !full_q;
  assign rd_acc = rd_en && !empty_q;

  // Next occupancy and sticky errors; a new error beats clear_err.
  always_comb begin
    level_d = level_q;
    if (wr_acc && !rd_acc) begin
      level_d = level_q + LW'(1);
    end else if (rd_acc && !wr_acc) begin
      level_d = level_q - LW'(1);
    end
    overflow_d  = (overflow_q && !clear_err) || (wr_en && full_q);
    underflow_d = (underflow_q && !clear_err) || (rd_en && empty_q);
  end

  // Pointers, level, flags (from next level) and error state.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      afull_q     <= 1'b0;
      aempty_q    <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      if (rd_acc) rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
      level_q     <= level_d;
      empty_q     <= (level_d == '0);
      full_q      <= (level_d == DEPTH_L);
      afull_q     <= (level_d >= AF_L);
      aempty_q    <= (level_d <= AE_L);
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  sync_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr_q),
    .wdata (wr_data),
    .raddr (rd_ptr_q),
    .rdata (mem_rdata)
  );

  if (MODE == MODE_FWFT) begin : g_fwft
    // Head word shown directly; forced to zero while empty so stale memory never leaks.
    assign rd_data = empty_q ? '0 : mem_rdata;
    assign valid   = !empty_q;
  end else begin : g_std
    logic [DATA_W-1:0] rd_data_q;
    logic              valid_q;

    // Registered read: data loads on an accepted read, valid pulses one cycle later.
    always_ff @(posedge clk) begin
      if (reset) begin
        rd_data_q <= '0;
        valid_q   <= 1'b0;
      end else begin
        valid_q <= rd_acc;
        if (rd_acc) rd_data_q <= mem_rdata;
      end
    end

    assign rd_data = rd_data_q;
    assign valid   = valid_q;
  end

  assign empty        = empty_q;
  assign full         = full_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign level        = level_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: standard and FWFT instances driven with the same directed
// stimulus, checked every cycle against a queue model plus hand-computed literals.
module tb_sync_fifo_param;

  localparam int unsigned DW = 32;
  localparam int unsigned DP = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_en = 1'b0;
  logic          clear_err = 1'b0;

  logic [DW-1:0] s_rd_data, f_rd_data;
  logic          s_valid, s_empty, s_full, s_af, s_ae, s_ovf, s_unf;
  logic          f_valid, f_empty, f_full, f_af, f_ae, f_ovf, f_unf;
  logic [4:0]    s_level, f_level;

  sync_fifo_param #(.DATA_W(DW), .DEPTH(DP), .FWFT(0)) dut_std (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(s_rd_data), .valid(s_valid), .empty(s_empty), .full(s_full),
    .almost_full(s_af), .almost_empty(s_ae), .level(s_level), .overflow(s_ovf),
    .underflow(s_unf), .clear_err(clear_err)
  );

  sync_fifo_param #(.DATA_W(DW), .DEPTH(DP), .FWFT(1)) dut_fwft (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(f_rd_data), .valid(f_valid), .empty(f_empty), .full(f_full),
    .almost_full(f_af), .almost_empty(f_ae), .level(f_level), .overflow(f_ovf),
    .underflow(f_unf), .clear_err(clear_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of stored words plus sticky errors and the registered read.
  logic [DW-1:0] q[$];
  bit            m_ovf = 1'b0, m_unf = 1'b0, m_valid = 1'b0;
  logic [DW-1:0] m_rd = '0;

  always @(posedge clk) begin
    bit wa, ra;
    if (reset) begin
      q.delete();
      m_ovf = 1'b0; m_unf = 1'b0; m_valid = 1'b0; m_rd = '0;
    end else begin
      wa = wr_en && (q.size() < DP);
      ra = rd_en && (q.size() > 0);
      m_ovf = (m_ovf && !clear_err) || (wr_en && q.size() == DP);
      m_unf = (m_unf && !clear_err) || (rd_en && q.size() == 0);
      m_valid = ra;
      if (ra) m_rd = q.pop_front();
      if (wa) q.push_back(wr_data);
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      int n;
      n = q.size();
      check("std_level", DW'(s_level), DW'(n));
      check("std_empty", DW'(s_empty), DW'(n == 0));
      check("std_full", DW'(s_full), DW'(n == DP));
      check("std_af", DW'(s_af), DW'(n >= DP - 2));
      check("std_ae", DW'(s_ae), DW'(n <= 2));
      check("std_ovf", DW'(s_ovf), DW'(m_ovf));
      check("std_unf", DW'(s_unf), DW'(m_unf));
      check("std_valid", DW'(s_valid), DW'(m_valid));
      check("std_rd_data", s_rd_data, m_rd);
      check("fwft_level", DW'(f_level), DW'(n));
      check("fwft_empty", DW'(f_empty), DW'(n == 0));
      check("fwft_full", DW'(f_full), DW'(n == DP));
      check("fwft_af", DW'(f_af), DW'(n >= DP - 2));
      check("fwft_ae", DW'(f_ae), DW'(n <= 2));
      check("fwft_ovf", DW'(f_ovf), DW'(m_ovf));
      check("fwft_unf", DW'(f_unf), DW'(m_unf));
      check("fwft_valid", DW'(f_valid), DW'(n != 0));
      check("fwft_rd_data", f_rd_data, (n != 0) ? q[0] : '0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    step();
    chk_en = 1'b1;
    step();
    reset = 1'b0;
    step();
    step();
    // Reset/idle state in both modes.
    check("lit_rst_empty", DW'(s_empty), 1);
    check("lit_rst_ae", DW'(f_ae), 1);
    check("lit_rst_level", DW'(s_level), 0);
    check("lit_rst_valid", DW'(s_valid), 0);
    check("lit_rst_fvalid", DW'(f_valid), 0);
    check("lit_rst_errs", DW'({s_ovf, s_unf, f_ovf, f_unf}), 0);

    // Fill with 0..15.
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = DW'(i);
      step();
      if (i == 12) check("lit_af_13", DW'(s_af), 0);
      if (i == 13) check("lit_af_14", DW'(s_af), 1);
    end
    wr_en = 1'b0;
    check("lit_full", DW'(s_full), 1);
    check("lit_level16", DW'(s_level), 16);

    // Write while full is rejected and sets overflow until cleared.
    wr_en = 1'b1; wr_data = 32'hDEAD;
    step();
    wr_en = 1'b0;
    step();
    check("lit_ovf", DW'(s_ovf), 1);
    check("lit_ovf_level", DW'(f_level), 16);
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    check("lit_ovf_clr", DW'(s_ovf), 0);

    // Drain 16 words: data appears one cycle after each rd_en.
    for (int i = 0; i < 16; i++) begin
      if (i == 0) check("lit_fwft_head", f_rd_data, 0);
      rd_en = 1'b1;
      step();
      check("lit_rd_data", s_rd_data, DW'(i));
      check("lit_rd_valid", DW'(s_valid), 1);
    end
    rd_en = 1'b0;
    step();
    check("lit_drained", DW'(s_empty), 1);
    check("lit_drained_v", DW'(s_valid), 0);

    // Simultaneous write/read on empty: write taken, read rejected.
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 32'h77;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    check("lit_wr_rd_empty_lvl", DW'(s_level), 1);
    check("lit_unf", DW'(s_unf), 1);
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("lit_0x77", s_rd_data, 32'h77);

    // Level 8 steady-state streaming with pointer wrap.
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_data = DW'(100 + i);
      step();
    end
    for (int i = 0; i < 40; i++) begin
      wr_en = 1'b1; rd_en = 1'b1; wr_data = DW'(i);
      step();
      if (i == 0) check("lit_oldest", s_rd_data, 100);
      check("lit_level8", DW'(s_level), 8);
    end
    wr_en = 1'b0;
    for (int i = 0; i < 8; i++) step();
    rd_en = 1'b0;
    check("lit_last", s_rd_data, 39);

    // FWFT: word appears without rd_en, pop empties.
    step();
    wr_en = 1'b1; wr_data = 32'hA5;
    step();
    wr_en = 1'b0;
    check("lit_fwft_a5", f_rd_data, 32'hA5);
    check("lit_fwft_v", DW'(f_valid), 1);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("lit_fwft_empty", DW'(f_empty), 1);
    check("lit_fwft_v0", DW'(f_valid), 0);

    // Reset mid-operation discards stored data.
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = DW'(200 + i);
      step();
    end
    wr_en = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("lit_rst_mid", DW'(s_level), 0);
    check("lit_rst_mid_v", DW'(f_valid), 0);
    wr_en = 1'b1; wr_data = 32'h5;
    step();
    wr_en = 1'b0;
    check("lit_post_rst_wr", DW'(s_empty), 0);
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
